nco_wavegen: RTL and testbench
==============================

// Module: nco_wavegen
// PURPOSE
//  Parametrised numerically-controlled oscillator generating the modulating waveform for the AM modulator datapath.
//  Phase accumulator with runtime tuning word, phase offset and 4 selectable shapes (sine, saw, triangle, square).
//  Sine from internal 64x8 quarter-wave table (no vendor ROM). Output is offset-binary DAC code.
//  FTW/mode changes are glitch-free: applied at accumulator wrap.
// PARAMETERS
//  ACC_W    24  accumulator/FTW/offset width; legal range >= OUT_W+2 and >= 10
//  OUT_W     8  output code width, 8..16; mid-scale MID = 2**(OUT_W-1)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      reset, synchronous, ACTIVE-HIGH (despite name); all state cleared while high
//  enable     in   1      1 = accumulator advances each cycle; 0 = hold phase
//  ftw_in     in   ACC_W  frequency tuning word; f_out = f_clk*FTW/2**ACC_W
//  ftw_load   in   1      1-cycle strobe: capture ftw_in + mode_in into shadow regs, set pending
//  mode_in    in   2      00 sine, 01 saw, 10 triangle, 11 square
//  phase_ofs  in   ACC_W  phase offset added before shaping, sampled every cycle
//  sync_clr   in   1      zero accumulator next cycle (multi-channel phase alignment)
//  wave_out   out  OUT_W  waveform code, registered
//  wave_valid out  1      wave_out holds a sample from an enabled cycle
//  wrap       out  1      1-cycle pulse: accumulator overflowed this update
// BEHAVIOUR
//  Reset: acc=0, active FTW=0, active mode=00, shadows=0, pending=0, wave_out=MID, wave_valid=0, wrap=0.
//  Priority per cycle: rst_n > sync_clr > enable-advance > hold.
//  Advance: {carry,acc} <= acc + ftw_act (mod 2**ACC_W); wrap <= carry. FTW=0 holds phase, never wraps.
//  Pending apply: if pending and (carry this cycle, or enable=0, or sync_clr): ftw_act/mode_act <= shadow, pending <= 0.
//  Applied FTW is first used on the following add. ftw_load with apply in same cycle: new load wins, stays pending.
//  sync_clr: acc <= 0, wrap <= 0, applies pending immediately; works regardless of enable.
//  Pipeline S1: p = acc + phase_ofs (mod 2**ACC_W) registered. S2: shape(p) -> wave_out registered.
//  Latency: wave_out reflects acc value of 2 cycles earlier; wave_valid = enable delayed 2 cycles.
//  Shapes (p bits: msb = p[ACC_W-1]):
//   sine: Qd = p[ACC_W-1:ACC_W-2], i = p[ACC_W-3 -: 6].
//         q[k] = round(127*sin(pi/2*(k+0.5)/64)).
//         Q0: 128+q[i]; Q1: 128+q[63-i]; Q2: 127-q[i]; Q3: 127-q[63-i].
//         Result 8-bit, left-aligned to OUT_W, zero LSBs.
//   saw:  p[ACC_W-1 -: OUT_W].
//   tri:  t = p[ACC_W-2 -: OUT_W]; msb ? ~t : t.
//   square: msb ? 0 : all-ones.
//  Mode is sampled with the phase in S1, so shape and phase always switch on the same sample.
// CONFIGURATION
//  `NCO_AMP_SCALE_EN defined:
//   - Adds input amp[7:0] and stage S3.
//   - out = MID + ((signed(w - MID) * amp) >>> 8), computed at OUT_W+9 bits.
//   - amp=0 gives MID. Latency 3, wave_valid delayed 3.
//   - Reset value MID.
//  Not defined: no amp port, latency 2, full-scale output.
// TESTING (ACC_W=24, OUT_W=8)
//  1 Reset: hold rst_n=1 for 3 clk while ftw_load pulses.
//    -> wave_out=128, wave_valid=0, wrap=0; FTW stays 0 after release.
//  2 Saw: FTW=0x010000, mode 01, enable=1.
//    -> wave_out 0,1,2..255 steps of 1 per clk; wrap every 256 clk; wave_valid high 2 clk after enable.
//  3 Sine: FTW=0x010000, mode 00.
//    -> code 130 at acc=0; 255 at acc=0x400000; 125 at 0x800000; 0 at 0xC00000.
//  4 Glitch-free retune: load FTW=0x020000 mid-period.
//    -> old 256-clk period completes, wrap, then 128-clk period; no discontinuity.
//  5 sync_clr + offset: phase_ofs=0x800000, saw, pulse sync_clr.
//    -> 2 clk later wave_out=128; a pending load applies at that clear.
//  6 `NCO_AMP_SCALE_EN, amp=128, square:
//    -> out alternates 191/64; amp=0 -> constant 128; latency 3 clk.

Source files
------------

// File: rtl/nco_wavegen.sv
// Phase-accumulator NCO with sine/saw/triangle/square shaping and offset-binary output.
// Optional amplitude scaling stage enabled by defining NCO_AMP_SCALE_EN.
module nco_wavegen #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [ACC_W-1:0] ftw_in,
    input  logic             ftw_load,
    input  logic [1:0]       mode_in,
    input  logic [ACC_W-1:0] phase_ofs,
    input  logic             sync_clr,
`ifdef NCO_AMP_SCALE_EN
    input  logic [7:0]       amp,
`endif
    output logic [OUT_W-1:0] wave_out,
    output logic             wave_valid,
    output logic             wrap
);

`ifdef NCO_AMP_SCALE_EN
    localparam int STAGES = 3;
`else
    localparam int STAGES = 2;
`endif
    // Only the top OUT_W+1 phase bits ever reach the shaper.
    localparam int P_W = OUT_W + 1;
    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

    localparam logic [6:0] SINE_Q [64] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    logic [ACC_W-1:0] acc, ftw_act, ftw_sh;
    logic [1:0]       mode_act, mode_sh, mode_s1;
    logic             pending;
    logic [ACC_W:0]   sum;
    logic             apply;
    logic [P_W-1:0]   p_s1;
    logic [OUT_W-1:0] wave_s2;
    logic [STAGES:1]  vld_pipe;

    assign sum   = {1'b0, acc} + {1'b0, ftw_act};
    // Shadowed tuning/mode only take effect at a phase wrap, a clear, or while idle.
    assign apply = pending & (sync_clr | ~enable | sum[ACC_W]);

    logic             msb;
    logic [5:0]       sidx;
    logic [6:0]       q;
    logic [7:0]       s8;
    logic [OUT_W-1:0] tri_t, shape_w;

    always_comb begin
        msb   = p_s1[P_W-1];
        sidx  = p_s1[P_W-2] ? ~p_s1[P_W-3 -: 6] : p_s1[P_W-3 -: 6];
        q     = SINE_Q[sidx];
        s8    = 8'd128 + {1'b0, q};
        if (msb) s8 = ~s8;
        tri_t = p_s1[P_W-2 -: OUT_W];
        case (mode_s1)
            2'b00:   shape_w = OUT_W'(s8) << (OUT_W - 8);
            2'b01:   shape_w = p_s1[P_W-1 -: OUT_W];
            2'b10:   shape_w = msb ? ~tri_t : tri_t;
            default: shape_w = msb ? '0 : '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc      <= '0;
            ftw_act  <= '0;
            mode_act <= 2'b00;
            ftw_sh   <= '0;
            mode_sh  <= 2'b00;
            pending  <= 1'b0;
            wrap     <= 1'b0;
            p_s1     <= '0;
            mode_s1  <= 2'b00;
            wave_s2  <= MID;
            vld_pipe <= '0;
        end else begin
            if (sync_clr) begin
                acc  <= '0;
                wrap <= 1'b0;
            end else if (enable) begin
                acc  <= sum[ACC_W-1:0];
                wrap <= sum[ACC_W];
            end else begin
                wrap <= 1'b0;
            end
            if (apply) begin
                ftw_act  <= ftw_sh;
                mode_act <= mode_sh;
                pending  <= 1'b0;
            end
            // A load coinciding with an apply keeps the newer word pending.
            if (ftw_load) begin
                ftw_sh  <= ftw_in;
                mode_sh <= mode_in;
                pending <= 1'b1;
            end
            p_s1     <= P_W'((acc + phase_ofs) >> (ACC_W - P_W));
            mode_s1  <= mode_act;
            wave_s2  <= shape_w;
            vld_pipe <= {vld_pipe[STAGES-1:1], enable};
        end
    end

`ifdef NCO_AMP_SCALE_EN
    // Offset-binary to signed is an msb flip; scale by amp/256 and flip back.
    logic [OUT_W-1:0] scaled;
    always_comb
        scaled = OUT_W'(({{9{~wave_s2[OUT_W-1]}}, ~wave_s2[OUT_W-1], wave_s2[OUT_W-2:0]}
                         * {{(OUT_W+1){1'b0}}, amp}) >> 8);

    always_ff @(posedge clk) begin
        if (rst_n) wave_out <= MID;
        else       wave_out <= {~scaled[OUT_W-1], scaled[OUT_W-2:0]};
    end
`else
    assign wave_out = wave_s2;
`endif

    assign wave_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_nco_wavegen.sv
// Directed self-checking bench for nco_wavegen (ACC_W=24, OUT_W=8).
module tb_nco_wavegen;
    localparam int ACC_W = 24;
    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             enable = 1'b0;
    logic [ACC_W-1:0] ftw_in = '0;
    logic             ftw_load = 1'b0;
    logic [1:0]       mode_in = 2'b00;
    logic [ACC_W-1:0] phase_ofs = '0;
    logic             sync_clr = 1'b0;
`ifdef NCO_AMP_SCALE_EN
    logic [7:0]       amp = 8'd0;
`endif
    logic [OUT_W-1:0] wave_out;
    logic             wave_valid;
    logic             wrap;

    int n_chk = 0;
    int n_fail = 0;

    nco_wavegen #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ftw_in(ftw_in),
        .ftw_load(ftw_load), .mode_in(mode_in), .phase_ofs(phase_ofs),
        .sync_clr(sync_clr),
`ifdef NCO_AMP_SCALE_EN
        .amp(amp),
`endif
        .wave_out(wave_out), .wave_valid(wave_valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1; enable = 1'b0; ftw_load = 1'b0; sync_clr = 1'b0; phase_ofs = '0;
        repeat (2) tick();
        rst_n = 1'b0;
    endtask

    // Load while idle so the word applies on the next edge, then start advancing.
    task automatic setup(input logic [ACC_W-1:0] ftw, input logic [1:0] mode);
        do_reset();
        ftw_in = ftw; mode_in = mode; ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0;
        tick();
        enable = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_idle;
        rst_n = 1'b1; enable = 1'b0; ftw_in = 24'h123456; mode_in = 2'b01;
        for (int i = 0; i < 3; i++) begin
            ftw_load = (i != 1);
            tick();
        end
        n_chk++; if (wave_out !== 8'd128) begin n_fail++; $display("FAIL reset_wave: got %0d want 128", wave_out); end
        n_chk++; if (wave_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", wave_valid); end
        n_chk++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        rst_n = 1'b0; ftw_load = 1'b0; mode_in = 2'b00; enable = 1'b1;
`ifdef NCO_AMP_SCALE_EN
        exp_idle = 8'd128;
`else
        exp_idle = 8'd130;
`endif
        for (int i = 0; i < 12; i++) begin
            tick();
            n_chk++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL post_reset_wrap[%0d]: got %b want 0", i, wrap); end
        end
        n_chk++; if (wave_out !== exp_idle) begin n_fail++; $display("FAIL post_reset_ftw0: got %0d want %0d", wave_out, exp_idle); end
        n_chk++; if (wave_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_valid: got %b want 1", wave_valid); end
        enable = 1'b0;
    endtask

`ifndef NCO_AMP_SCALE_EN
    task automatic test_saw();
        setup(24'h010000, 2'b01);
        tick();
        n_chk++; if (wave_valid !== 1'b0) begin n_fail++; $display("FAIL saw_valid_early: got %b want 0", wave_valid); end
        tick();
        n_chk++; if (wave_valid !== 1'b1) begin n_fail++; $display("FAIL saw_valid: got %b want 1", wave_valid); end
        for (int j = 0; j < 300; j++) begin
            if (j > 0) tick();
            n_chk++; if (wave_out !== 8'(j)) begin n_fail++; $display("FAIL saw_wave[%0d]: got %0d want %0d", j, wave_out, j % 256); end
            n_chk++; if (wrap !== 1'((j + 2) % 256 == 0)) begin n_fail++; $display("FAIL saw_wrap[%0d]: got %b", j, wrap); end
        end
    endtask

    task automatic test_sine();
        logic [7:0] exp;
        logic       chk;
        setup(24'h010000, 2'b00);
        repeat (2) tick();
        for (int j = 0; j <= 256; j++) begin
            if (j > 0) tick();
            chk = 1'b1;
            case (j)
                0:       exp = 8'd130;
                64:      exp = 8'd255;
                128:     exp = 8'd125;
                192:     exp = 8'd0;
                256:     exp = 8'd130;
                default: begin exp = 8'd0; chk = 1'b0; end
            endcase
            if (chk) begin
                n_chk++; if (wave_out !== exp) begin n_fail++; $display("FAIL sine[%0d]: got %0d want %0d", j, wave_out, exp); end
            end
        end
    endtask

    task automatic test_retune();
        int exp_w;
        logic exp_wr;
        setup(24'h010000, 2'b01);
        repeat (2) tick();
        for (int j = 0; j <= 540; j++) begin
            if (j > 0) tick();
            ftw_load = 1'b0;
            exp_w  = (j <= 256) ? (j % 256) : ((2 * (j - 256)) % 256);
            exp_wr = (j == 254) || (j > 254 && (j - 254) % 128 == 0);
            n_chk++; if (wave_out !== 8'(exp_w)) begin n_fail++; $display("FAIL retune_wave[%0d]: got %0d want %0d", j, wave_out, exp_w); end
            n_chk++; if (wrap !== exp_wr) begin n_fail++; $display("FAIL retune_wrap[%0d]: got %b want %b", j, wrap, exp_wr); end
            if (j == 99) begin ftw_in = 24'h020000; mode_in = 2'b01; ftw_load = 1'b1; end
        end
    endtask

    task automatic test_sync_clr();
        setup(24'h010000, 2'b01);
        phase_ofs = 24'h800000;
        repeat (52) tick();
        ftw_in = 24'h030000; mode_in = 2'b01; ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0; sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        n_chk++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL sync_wrap: got %b want 0", wrap); end
        repeat (2) tick();
        n_chk++; if (wave_out !== 8'd128) begin n_fail++; $display("FAIL sync_wave0: got %0d want 128", wave_out); end
        tick();
        n_chk++; if (wave_out !== 8'd131) begin n_fail++; $display("FAIL sync_wave1: got %0d want 131", wave_out); end
        tick();
        n_chk++; if (wave_out !== 8'd134) begin n_fail++; $display("FAIL sync_wave2: got %0d want 134", wave_out); end
    endtask

    task automatic test_hold();
        setup(24'h010000, 2'b01);
        repeat (22) tick();
        n_chk++; if (wave_out !== 8'd20) begin n_fail++; $display("FAIL hold_pre: got %0d want 20", wave_out); end
        enable = 1'b0;
        tick();
        n_chk++; if (wave_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid1: got %b want 1", wave_valid); end
        tick();
        n_chk++; if (wave_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid0: got %b want 0", wave_valid); end
        n_chk++; if (wave_out !== 8'd22) begin n_fail++; $display("FAIL hold_wave: got %0d want 22", wave_out); end
        repeat (4) tick();
        n_chk++; if (wave_out !== 8'd22) begin n_fail++; $display("FAIL hold_wave_late: got %0d want 22", wave_out); end
        n_chk++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL hold_wrap: got %b want 0", wrap); end
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        repeat (2) tick();
        n_chk++; if (wave_out !== 8'd0) begin n_fail++; $display("FAIL hold_sync: got %0d want 0", wave_out); end
    endtask
`else
    task automatic test_amp();
        amp = 8'd128;
        setup(24'h800000, 2'b11);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) begin
                n_chk++; if (wave_valid !== 1'b0) begin n_fail++; $display("FAIL amp_valid_early: got %b want 0", wave_valid); end
            end
            if (k >= 3) begin
                n_chk++; if (wave_valid !== 1'b1) begin n_fail++; $display("FAIL amp_valid[%0d]: got %b want 1", k, wave_valid); end
                n_chk++; if (wave_out !== ((k % 2) ? 8'd191 : 8'd64)) begin n_fail++; $display("FAIL amp_sq[%0d]: got %0d want %0d", k, wave_out, (k % 2) ? 191 : 64); end
            end
        end
        amp = 8'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++; if (wave_out !== 8'd128) begin n_fail++; $display("FAIL amp_zero[%0d]: got %0d want 128", k, wave_out); end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef NCO_AMP_SCALE_EN
        test_saw();
        test_sine();
        test_retune();
        test_sync_clr();
        test_hold();
`else
        test_amp();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
